// File: rtl/cpu_pkg.sv
// Shared constants and types for the single-cycle MIPS core.
// Used by the fetch stage and by anything that builds or decodes instruction words.
package cpu_pkg;

  localparam int          IMEM_AW_DEF  = 14;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam logic [5:0]  OP_J   = 6'b000010;
  localparam logic [5:0]  OP_JAL = 6'b000011;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_HOLD   = 3'd4,
    SEL_RESET  = 3'd5
  } npc_sel_e;

  // Pseudo-direct j/jal target: region bits of PC+4 with the 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                              input logic [25:0] index);
    return {pc_plus_4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction memory: asynchronous read for fetch, synchronous write for
// the UART programming port. Contents are not affected by reset.
module instr_rom #(
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [0:(2**AW)-1];

  // programming write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC register, next-PC selection, sticky bad-target flag and
// the programming-session word counter around the instruction memory.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW  = IMEM_AW_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        Addr_Result,
  input  logic               Zero,
  input  logic [31:0]        Read_data_1,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               stall,
  input  logic               upg_en,
  input  logic               upg_wen,
  input  logic [IMEM_AW-1:0] upg_adr,
  input  logic [31:0]        upg_dat,
  output logic [31:0]        Instruction,
  output logic [31:0]        branch_base_addr,
  output logic [31:0]        link_addr,
  output logic [31:0]        pc_out,
  output logic               addr_exc,
  output logic [IMEM_AW:0]   prog_count
);

  localparam logic [IMEM_AW:0] PROG_SAT = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] PROG_ONE = {{IMEM_AW{1'b0}}, 1'b1};

  logic [31:0]      pc_r;
  logic             addr_exc_r;
  logic [IMEM_AW:0] prog_count_r;
  logic             upg_en_d_r;

  logic [31:0]      rom_rdata_s;
  logic [31:0]      pc_plus_4_s;
  logic [31:0]      next_pc_s;
  npc_sel_e         npc_sel_s;
  logic             br_taken_s;
  logic             jr_misaligned_s;
  logic             out_of_range_s;
  logic [IMEM_AW:0] prog_base_s;
  logic [IMEM_AW:0] prog_next_s;
  logic             rom_we_s;
  logic             unused_ok_s;

  // A write landing on a reset edge is discarded.
  assign rom_we_s = upg_en & upg_wen & ~reset;

  instr_rom #(.AW(IMEM_AW)) u_rom (
    .clock (clock),
    .we    (rom_we_s),
    .waddr (upg_adr),
    .wdata (upg_dat),
    .raddr (pc_r[IMEM_AW+1:2]),
    .rdata (rom_rdata_s)
  );

  assign pc_plus_4_s      = pc_r + 32'd4;
  assign Instruction      = upg_en ? NOP_INSTR : rom_rdata_s;
  assign branch_base_addr = pc_plus_4_s;
  assign link_addr        = pc_plus_4_s;
  assign pc_out           = pc_r;
  assign addr_exc         = addr_exc_r;
  assign prog_count       = prog_count_r;
  assign br_taken_s       = (Branch & Zero) | (nBranch & ~Zero);

  // next-PC source priority
  always_comb begin
    npc_sel_s = SEL_SEQ;
    if (upg_en) begin
      npc_sel_s = SEL_RESET;
    end else if (stall) begin
      npc_sel_s = SEL_HOLD;
    end else if (Jr) begin
      npc_sel_s = SEL_JR;
    end else if (Jmp | Jal) begin
      npc_sel_s = SEL_JUMP;
    end else if (br_taken_s) begin
      npc_sel_s = SEL_BRANCH;
    end else begin
      npc_sel_s = SEL_SEQ;
    end
  end

  // next-PC value; the branch target arrives in words
  always_comb begin
    next_pc_s = pc_plus_4_s;
    case (npc_sel_s)
      SEL_RESET:  next_pc_s = RESET_PC;
      SEL_HOLD:   next_pc_s = pc_r;
      SEL_JR:     next_pc_s = {Read_data_1[31:2], 2'b00};
      SEL_JUMP:   next_pc_s = jump_target(pc_plus_4_s, rom_rdata_s[25:0]);
      SEL_BRANCH: next_pc_s = {Addr_Result[29:0], 2'b00};
      SEL_SEQ:    next_pc_s = pc_plus_4_s;
      default:    next_pc_s = pc_plus_4_s;
    endcase
  end

  assign jr_misaligned_s = (npc_sel_s == SEL_JR) && (Read_data_1[1:0] != 2'b00);
  assign out_of_range_s  = |next_pc_s[31:IMEM_AW+2];

  // session word counter: restarts on entry to programming mode, saturates at depth
  always_comb begin
    prog_base_s = upg_en_d_r ? prog_count_r : {(IMEM_AW+1){1'b0}};
    prog_next_s = prog_count_r;
    if (upg_en) begin
      if (upg_wen && (prog_base_s != PROG_SAT)) begin
        prog_next_s = prog_base_s + PROG_ONE;
      end else begin
        prog_next_s = prog_base_s;
      end
    end else begin
      prog_next_s = prog_count_r;
    end
  end

  // fetch state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      addr_exc_r   <= 1'b0;
      prog_count_r <= {(IMEM_AW+1){1'b0}};
      upg_en_d_r   <= 1'b0;
    end else begin
      pc_r         <= next_pc_s;
      addr_exc_r   <= addr_exc_r | jr_misaligned_s | out_of_range_s;
      prog_count_r <= prog_next_s;
      upg_en_d_r   <= upg_en;
    end
  end

  assign unused_ok_s = ^{Addr_Result[31:30], rom_rdata_s[31:26],
                         pc_r[31:IMEM_AW+2], pc_r[1:0]};

endmodule
